// File: rtl/seg_scan_counter_pkg.sv
// seg_pkg: shared constants, digit-index type and helpers for the seg_scan_counter slice.
package seg_pkg;

    localparam int NUM_DIGITS = 4;
    localparam logic [3:0] BCD_MAX = 4'd9;
    localparam logic [3:0] BLANK_CODE = 4'hF;

    typedef logic [1:0] dig_idx_t;

    function automatic logic [NUM_DIGITS-1:0] onehot(input dig_idx_t idx);
        onehot = '0;
        onehot[idx] = 1'b1;
    endfunction

    function automatic logic bcd_valid(input logic [4*NUM_DIGITS-1:0] v);
        bcd_valid = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++)
            bcd_valid &= (v[4*i +: 4] <= BCD_MAX);
    endfunction

endpackage

// File: rtl/seg_scan_counter_if.sv
// seg_scan_counter_if: control strobes, count status and display-scan lines of seg_scan_counter.
interface seg_scan_counter_if;
    logic        inc;
    logic        up_dn;
    logic        clr;
    logic        load;
    logic [15:0] load_val;
    logic [15:0] count;
    logic        carry;
    logic        load_err;
    logic [3:0]  sin;
    logic [3:0]  dig_sel;

    modport master (
        output inc, up_dn, clr, load, load_val,
        input  count, carry, load_err, sin, dig_sel
    );

    modport slave (
        input  inc, up_dn, clr, load, load_val,
        output count, carry, load_err, sin, dig_sel
    );
endinterface

// File: rtl/seg_scan_counter_bcd_digit.sv
// bcd_digit: one registered BCD cell; co is the combinational carry/borrow into the next cell.
module bcd_digit
    import seg_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       step,
    input  logic       up_dn,
    input  logic       clr,
    input  logic       load,
    input  logic [3:0] load_val,
    output logic [3:0] digit,
    output logic       co
);
    logic [3:0] digit_q, digit_d;
    logic       wrap;

    always_comb begin
        wrap    = up_dn ? (digit_q == BCD_MAX) : (digit_q == 4'd0);
        digit_d = clr   ? 4'd0 :
                  load  ? load_val :
                  !step ? digit_q :
                  wrap  ? (up_dn ? 4'd0 : BCD_MAX) :
                  up_dn ? digit_q + 4'd1 : digit_q - 4'd1;
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) digit_q <= 4'd0;
        else        digit_q <= digit_d;

    assign digit = digit_q;
    assign co    = step && !clr && !load && wrap;
endmodule

// File: rtl/seg_scan_counter.sv
// seg_scan_counter: 4-digit BCD up/down counter with a time-multiplexed digit scanner.
// Define SEG_SCAN_BLANK_LZ_EN to blank leading zeros on digits 1..3.
module seg_scan_counter
    import seg_pkg::*;
#(
    parameter int SCAN_DIV = 50000,
    parameter int CNT_W    = 20
)
(
    input logic clk,
    input logic rst_n,
    seg_scan_counter_if.slave bus
);
    logic [CNT_W-1:0]    pre_q, pre_d;
    dig_idx_t            idx_q, idx_d;
    logic                carry_q, carry_d;
    logic                load_err_q, load_err_d;
    logic [3:0]          sin_q, sin_d;
    logic [3:0]          dig_sel_q, dig_sel_d;
    logic [15:0]         count;
    logic [NUM_DIGITS:0] step;
    logic                load_ok;
    logic                pre_term;
    logic [3:0]          nib;

    // clr and any load (even a rejected one) suppress inc for the cycle
    assign load_ok = bus.load && bcd_valid(bus.load_val);
    assign step[0] = bus.inc && !bus.clr && !bus.load;

    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_dig
        bcd_digit u_dig (
            .clk      (clk),
            .rst_n    (rst_n),
            .step     (step[i]),
            .up_dn    (bus.up_dn),
            .clr      (bus.clr),
            .load     (load_ok),
            .load_val (bus.load_val[4*i +: 4]),
            .digit    (count[4*i +: 4]),
            .co       (step[i+1])
        );
    end

    always_comb begin
        pre_term   = (pre_q == CNT_W'(SCAN_DIV - 1));
        pre_d      = pre_term ? '0 : pre_q + 1'b1;
        idx_d      = pre_term ? idx_q + 1'b1 : idx_q;
        carry_d    = step[NUM_DIGITS];
        load_err_d = bus.load && !bus.clr && !bcd_valid(bus.load_val);
        nib        = count[4*idx_q +: 4];
`ifdef SEG_SCAN_BLANK_LZ_EN
        sin_d      = (idx_q != 2'd0 && (count >> (4*idx_q)) == 16'd0) ? BLANK_CODE : nib;
`else
        sin_d      = nib;
`endif
        dig_sel_d  = onehot(idx_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q      <= '0;
            idx_q      <= '0;
            carry_q    <= 1'b0;
            load_err_q <= 1'b0;
            sin_q      <= 4'd0;
            dig_sel_q  <= 4'b0001;
        end else begin
            pre_q      <= pre_d;
            idx_q      <= idx_d;
            carry_q    <= carry_d;
            load_err_q <= load_err_d;
            sin_q      <= sin_d;
            dig_sel_q  <= dig_sel_d;
        end
    end

    assign bus.count    = count;
    assign bus.carry    = carry_q;
    assign bus.load_err = load_err_q;
    assign bus.sin      = sin_q;
    assign bus.dig_sel  = dig_sel_q;
endmodule

// File: tb/tb_seg_scan_counter.sv
// tb_seg_scan_counter: table-driven counter vectors plus hand-written scan, blanking and reset sequences.
module tb_seg_scan_counter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    seg_scan_counter_if bus ();

    seg_scan_counter #(.SCAN_DIV(4), .CNT_W(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        clr;
        logic        load;
        logic        inc;
        logic        up_dn;
        logic [15:0] load_val;
        logic [15:0] exp_count;
        logic        exp_carry;
        logic        exp_err;
    } vec_t;

    vec_t vecs [16];

    always @(negedge clk) begin
        checks++;
        if (!$onehot(bus.dig_sel)) begin
            errors++;
            $display("FAIL onehot dig_sel: got %b, want one-hot", bus.dig_sel);
        end
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic idle_strobes();
        bus.clr = 1'b0; bus.load = 1'b0; bus.inc = 1'b0;
    endtask

    task automatic pulse_load(input logic [15:0] v);
        bus.load = 1'b1; bus.load_val = v;
        @(posedge clk); #1;
        idle_strobes();
    endtask

    task automatic scan_check(input string tag, input logic [15:0] exp);
        logic [3:0] prev;
        int n = 0;
        do begin
            prev = bus.dig_sel;
            @(posedge clk); #1;
            n++;
        end while (!(prev == 4'b1000 && bus.dig_sel == 4'b0001) && n < 64);
        if (n >= 64) begin
            checks++; errors++;
            $display("FAIL %s sync: no 1000->0001 wrap within 64 cycles", tag);
        end else begin
            for (int k = 0; k < 16; k++) begin
                if (k != 0) begin @(posedge clk); #1; end
                chk({tag, " dig_sel"}, {12'd0, bus.dig_sel}, 16'(1) << (k / 4));
                chk({tag, " sin"}, {12'd0, bus.sin}, {12'd0, exp[4*(k/4) +: 4]});
            end
        end
    endtask

    initial begin
        //           clr   load  inc   up    load_val  count     cy    err
        vecs[0]  = '{1'b0, 1'b1, 1'b0, 1'b1, 16'h0999, 16'h0999, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 1'b1, 1'b1, 16'h0000, 16'h1000, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 1'b1, 16'h9999, 16'h9999, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 1'b1, 1'b1, 16'h0000, 16'h0000, 1'b1, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h9999, 1'b1, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0100, 16'h0100, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0099, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 1'b1, 1'b1, 16'h12A4, 16'h0099, 1'b0, 1'b1};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0099, 1'b0, 1'b0};
        vecs[10] = '{1'b1, 1'b1, 1'b1, 1'b1, 16'h1234, 16'h0000, 1'b0, 1'b0};
        vecs[11] = '{1'b1, 1'b1, 1'b1, 1'b0, 16'h12A4, 16'h0000, 1'b0, 1'b0};
        vecs[12] = '{1'b0, 1'b1, 1'b1, 1'b1, 16'h1234, 16'h1234, 1'b0, 1'b0};
        vecs[13] = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h1233, 1'b0, 1'b0};
        vecs[14] = '{1'b0, 1'b1, 1'b0, 1'b1, 16'h0019, 16'h0019, 1'b0, 1'b0};
        vecs[15] = '{1'b0, 1'b0, 1'b1, 1'b1, 16'h0000, 16'h0020, 1'b0, 1'b0};

        idle_strobes();
        bus.up_dn = 1'b1;
        bus.load_val = 16'h0000;
        repeat (3) @(posedge clk);
        #1;
        chk("reset count", bus.count, 16'h0000);
        chk("reset carry", {15'd0, bus.carry}, 16'd0);
        chk("reset load_err", {15'd0, bus.load_err}, 16'd0);
        chk("reset sin", {12'd0, bus.sin}, 16'd0);
        chk("reset dig_sel", {12'd0, bus.dig_sel}, 16'h0001);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int v = 0; v < 16; v++) begin
            bus.clr = vecs[v].clr; bus.load = vecs[v].load; bus.inc = vecs[v].inc;
            bus.up_dn = vecs[v].up_dn; bus.load_val = vecs[v].load_val;
            @(posedge clk); #1;
            idle_strobes();
            chk($sformatf("vec%0d count", v), bus.count, vecs[v].exp_count);
            chk($sformatf("vec%0d carry", v), {15'd0, bus.carry}, {15'd0, vecs[v].exp_carry});
            chk($sformatf("vec%0d load_err", v), {15'd0, bus.load_err}, {15'd0, vecs[v].exp_err});
        end

        pulse_load(16'h4321);
        scan_check("scan4321", 16'h4321);

        pulse_load(16'h0007);
`ifdef SEG_SCAN_BLANK_LZ_EN
        scan_check("blank0007", 16'hFFF7);
`else
        scan_check("raw0007", 16'h0007);
`endif
        bus.clr = 1'b1;
        @(posedge clk); #1;
        idle_strobes();
`ifdef SEG_SCAN_BLANK_LZ_EN
        scan_check("blank0000", 16'hFFF0);
`else
        scan_check("raw0000", 16'h0000);
`endif

        // asynchronous reset mid-scan while digit 2 is lit
        pulse_load(16'h9999);
        begin
            int n = 0;
            while (bus.dig_sel != 4'b0100 && n < 64) begin
                @(posedge clk); #1;
                n++;
            end
            chk("midscan reach digit 2", {12'd0, bus.dig_sel}, 16'h0004);
        end
        #2 rst_n = 1'b0;
        #1;
        chk("async rst count", bus.count, 16'h0000);
        chk("async rst dig_sel", {12'd0, bus.dig_sel}, 16'h0001);
        chk("async rst sin", {12'd0, bus.sin}, 16'd0);
        chk("async rst carry", {15'd0, bus.carry}, 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/seg_scan_counter.md
Name: seg_scan_counter

Overview:
- Four-digit BCD up/down counter with a time-multiplexed digit scanner.
- Sits directly upstream of the 7-segment decoder. Drives its 4-bit `sin` input and the one-hot digit-enable lines of a common-cathode 4-digit display.
- One digit is presented per scan slot. Each digit is refreshed once every 4*SCAN_DIV clocks.

Parameters:
- SCAN_DIV, 50000, clock cycles per digit slot; legal range 2..2^20.
- CNT_W, 20, prescaler width; must satisfy 2^CNT_W >= SCAN_DIV.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- inc  input  1  count-step strobe; one step per cycle it is high.
- up_dn  input  1  direction for inc: 1 = up, 0 = down.
- clr  input  1  synchronous clear of count to 0000.
- load  input  1  synchronous load of load_val.
- load_val  input  16  four BCD digits, [3:0] = digit 0 (least significant).
- count  output  16  current BCD count, registered.
- carry  output  1  one-cycle pulse on 9999->0000 (up) or 0000->9999 (down).
- load_err  output  1  one-cycle pulse when load is rejected.
- sin  output  4  BCD nibble for the currently selected digit, to the decoder.
- dig_sel  output  4  one-hot active-high digit enable; bit i lights digit i.

Behaviour:
- Reset is asynchronous and active-low: clock `clk`, reset `rst_n`. Reset acts immediately, mid-operation included, and overrides everything.
- Reset values:
  - count = 0, carry = 0, load_err = 0.
  - sin = 0, dig_sel = 4'b0001.
  - prescaler = 0, digit index = 0.
- Priority per cycle: clr > load > inc. The lower-priority strobes are ignored that cycle. carry is 0 on a clr or load cycle.
- Load validity:
  - load with every nibble of load_val <= 9: count <= load_val next cycle.
  - load with any nibble > 9: count unchanged, load_err = 1 for exactly one cycle.
- inc up: digit 0 increments. A digit at 9 wraps to 0 and ripples +1 into the next digit in the same cycle. 9999 -> 0000 with carry = 1 for one cycle.
- inc down: mirror behaviour. A digit at 0 wraps to 9 and borrows from the next digit. 0000 -> 9999 with carry = 1.
- count never holds a nibble > 9. Latency from strobe to count is one cycle.
- Scanner:
  - Free-running prescaler counts 0..SCAN_DIV-1 and runs regardless of inc/clr/load.
  - At terminal count, prescaler -> 0 and digit index advances 0->1->2->3->0.
- Outputs sin and dig_sel are registered from (index, count):
  - dig_sel = one-hot(index).
  - sin = count nibble[index].
  - One-cycle latency after an index or count change. A count change is visible on sin at the next clock without waiting for a slot boundary.
- dig_sel is always exactly one-hot; no all-zero or multi-hot cycle, including across the wrap 3->0.

Optional Feature:
- Macro: SEG_SCAN_BLANK_LZ_EN (leading-zero blanking).
- Defined: while digit i (i = 1..3) is selected and nibbles i..3 of count are all zero, sin = 4'hF. The decoder's default branch then blanks the digit. Digit 0 is never blanked, so 0000 shows "0".
- Undefined: sin always carries the raw nibble. No blanking logic is synthesised.

Decomposition:
- Package seg_pkg holds:
  - NUM_DIGITS = 4.
  - BCD_MAX = 4'd9.
  - BLANK_CODE = 4'hF.
  - Digit-index typedef (2 bits).
  - One-hot select function.
- Sub-module bcd_digit: one 4-bit BCD cell with inputs step, up_dn, clr, load, load value; outputs the digit and carry/borrow-out. It is instantiated four times, ripple-chained within a single cycle.

Test Plan:
- Reset mid-scan: assert rst_n = 0 with index = 2 -> immediately count = 0, dig_sel = 0001, sin = 0, carry = 0.
- Load 16'h0999, pulse inc up -> count = 1000 next cycle, carry = 0. Load 9999, inc up -> count = 0000, carry high for exactly one cycle.
- Count 0000, inc down -> 9999, carry = 1. Load 0100, inc down -> 0099.
- load_val = 16'h12A4 -> count unchanged, load_err = 1 for one cycle. clr + load + inc in the same cycle -> count = 0000, no carry, no load_err.
- SCAN_DIV = 4, count = 4321:
  - dig_sel sequence 0001, 0010, 0100, 1000, each for 4 clocks.
  - sin sequence 1, 2, 3, 4.
  - Checker asserts dig_sel is one-hot every cycle.
- SEG_SCAN_BLANK_LZ_EN defined, count = 0007 -> sin = 7, F, F, F across slots 0..3. Count = 0000 -> sin = 0, F, F, F. Macro undefined -> sin = 7, 0, 0, 0.
